// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Main sequencing FSM of the multicycle RV32I core. Each instruction is walked
// through fetch / decode / execute / memory / writeback states; in every state
// the controller drives the datapath enables and mux selects for that step and
// the 2-bit ALUOp consumed by alu_decoder. FETCH, MEMREAD and MEMWRITE stall on
// the single-cycle mem_ready handshake.
//
// Ports:
//   clk        in  1  sole clock, rising edge
//   reset      in  1  synchronous, active-high; forces every output to 0
//   op         in  7  opcode field of the instruction register
//   zero       in  1  ALU zero flag (branch condition)
//   mem_ready  in  1  memory completed the current access this cycle
//   PCWrite    out 1  PC register enable
//   AdrSrc     out 1  memory address select (0 = PC, 1 = ALUOut)
//   MemWrite   out 1  memory write strobe
//   IRWrite    out 1  instruction register / OldPC enable
//   RegWrite   out 1  register file write enable
//   ResultSrc  out 2  result mux (00 ALUOut, 01 Data, 10 ALUResult)
//   ALUSrcA    out 2  ALU A select (00 PC, 01 OldPC, 10 RD1)
//   ALUSrcB    out 2  ALU B select (00 RD2, 01 ImmExt, 10 constant 4)
//   ALUOp      out 2  to alu_decoder (00 add, 01 sub, 10 funct-decoded)
//   ImmSrc     out 2  immediate format (00 I, 01 S, 10 B, 11 J)
//   illegal    out 1  one-cycle pulse in DECODE on an unsupported opcode
//   state      out 4  current state, for debug
// -----------------------------------------------------------------------------
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_t state_r;
    state_t state_next_s;

    // Immediate format is a pure function of the opcode, independent of state.
    function automatic logic [1:0] imm_src_f(input logic [6:0] opcode);
        logic [1:0] imm;
        case (opcode)
            OP_LW:   imm = 2'b00;
            OP_IALU: imm = 2'b00;
            OP_SW:   imm = 2'b01;
            OP_BEQ:  imm = 2'b10;
            OP_JAL:  imm = 2'b11;
            default: imm = 2'b00;
        endcase
        return imm;
    endfunction

    // State register; reset loads FETCH on the first edge it is sampled high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and Moore outputs; reset overrides everything so an
    // instruction in flight (e.g. a pending store) never strobes.
    always_comb begin
        state_next_s = S_FETCH;
        PCWrite      = 1'b0;
        AdrSrc       = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ALUOp        = 2'b00;
        ImmSrc       = 2'b00;
        illegal      = 1'b0;
        state        = 4'd0;

        if (reset) begin
            state_next_s = S_FETCH;
        end else begin
            state  = state_r;
            ImmSrc = imm_src_f(op);
            case (state_r)
                S_FETCH: begin
                    // PC+4 computed on the ALU and written straight back.
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                    if (mem_ready) begin
                        state_next_s = S_DECODE;
                    end else begin
                        state_next_s = S_FETCH;
                    end
                end
                S_DECODE: begin
                    // OldPC + imm precomputes the branch/jump target.
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    case (op)
                        OP_LW:   state_next_s = S_MEMADR;
                        OP_SW:   state_next_s = S_MEMADR;
                        OP_RTYP: state_next_s = S_EXECUTER;
                        OP_IALU: state_next_s = S_EXECUTEI;
                        OP_JAL:  state_next_s = S_JAL;
                        OP_BEQ:  state_next_s = S_BEQ;
                        default: begin
                            state_next_s = S_FETCH;
                            illegal      = 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    // op[5] separates sw (1) from lw (0).
                    if (op[5]) begin
                        state_next_s = S_MEMWRITE;
                    end else begin
                        state_next_s = S_MEMREAD;
                    end
                end
                S_MEMREAD: begin
                    AdrSrc = 1'b1;
                    if (mem_ready) begin
                        state_next_s = S_MEMWB;
                    end else begin
                        state_next_s = S_MEMREAD;
                    end
                end
                S_MEMWB: begin
                    ResultSrc    = 2'b01;
                    RegWrite     = 1'b1;
                    state_next_s = S_FETCH;
                end
                S_MEMWRITE: begin
                    // Write strobe held for the whole wait on mem_ready.
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                    if (mem_ready) begin
                        state_next_s = S_FETCH;
                    end else begin
                        state_next_s = S_MEMWRITE;
                    end
                end
                S_EXECUTER: begin
                    ALUSrcA      = 2'b10;
                    ALUSrcB      = 2'b00;
                    ALUOp        = 2'b10;
                    state_next_s = S_ALUWB;
                end
                S_EXECUTEI: begin
                    ALUSrcA      = 2'b10;
                    ALUSrcB      = 2'b01;
                    ALUOp        = 2'b10;
                    state_next_s = S_ALUWB;
                end
                S_ALUWB: begin
                    ResultSrc    = 2'b00;
                    RegWrite     = 1'b1;
                    state_next_s = S_FETCH;
                end
                S_JAL: begin
                    // Jump target already in ALUOut; ALU forms OldPC+4 as link.
                    ALUSrcA      = 2'b01;
                    ALUSrcB      = 2'b10;
                    ResultSrc    = 2'b00;
                    PCWrite      = 1'b1;
                    state_next_s = S_ALUWB;
                end
                S_BEQ: begin
                    ALUSrcA      = 2'b10;
                    ALUSrcB      = 2'b00;
                    ALUOp        = 2'b01;
                    ResultSrc    = 2'b00;
                    PCWrite      = zero;
                    state_next_s = S_FETCH;
                end
                default: begin
                    // Unreachable encodings: all strobes low, recover to FETCH.
                    state_next_s = S_FETCH;
                end
            endcase
        end
    end

endmodule
